// File: rtl/fmeas_ctrl_if.sv
// fmeas_ctrl_if: measurement request/counter/result bundle between a client and the frequency-measurement controller
interface fmeas_ctrl_if #(
   parameter int LENGTH = 20,
   parameter int GATE_W = 16
);
   logic              start;
   logic [GATE_W-1:0] gate_cycles;
   logic [LENGTH-1:0] count_in;
   logic              cont;
   logic              cnt_reset;
   logic              gate;
   logic [LENGTH-1:0] result;
   logic              result_valid;
   logic              result_ready;
   logic              busy;
   modport master (
      output start, gate_cycles, count_in, cont, result_ready,
      input  cnt_reset, gate, result, result_valid, busy
   );
   modport slave (
      input  start, gate_cycles, count_in, cont, result_ready,
      output cnt_reset, gate, result, result_valid, busy
   );
endinterface

// File: rtl/fmeas_ctrl.sv
// fmeas_ctrl: gates an external cycle counter for a programmed window, lets it settle, then captures and hands off its count; FMEAS_CONT_EN enables back-to-back windows
module fmeas_ctrl #(
   parameter int LENGTH = 20,
   parameter int GATE_W = 16,
   parameter int SETTLE = 4
) (
   input logic        clk,
   input logic        rst_n,
   fmeas_ctrl_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_HOLD} state_t;
   localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);
   state_t            r_state, w_next;
   logic [GATE_W-1:0] r_cnt, w_cnt_nxt, w_reload;
   logic [3:0]        r_set, w_set_nxt;
   logic              w_capture, w_rearm;
   logic [LENGTH-1:0] r_result;
   logic              r_cnt_reset, r_gate, r_valid, r_busy;
`ifdef FMEAS_CONT_EN
   logic [GATE_W-1:0] r_len;
   assign w_rearm  = bus.cont;
   assign w_reload = r_len;
   // remember the accepted window length so continuous mode can re-arm without a new start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_len <= '0;
      else if (r_state == S_IDLE && bus.start) r_len <= bus.gate_cycles;
   end
`else
   logic w_cont_unused;
   assign w_cont_unused = bus.cont;
   assign w_rearm       = 1'b0;
   assign w_reload      = r_cnt;
`endif
   // next state, window down-counter and settle counter
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_set_nxt = '0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next    = S_CLEAR;
               w_cnt_nxt = bus.gate_cycles;
            end
         end
         S_CLEAR: w_next = (r_cnt == '0) ? S_SETTLE : S_GATE;
         S_GATE: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == GATE_W'(1)) w_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_set == SET_LAST) begin
               w_next    = S_HOLD;
               w_capture = 1'b1;
            end else begin
               w_set_nxt = r_set + 4'd1;
            end
         end
         S_HOLD: begin
            if (bus.result_ready) begin
               w_next    = w_rearm ? S_CLEAR : S_IDLE;
               w_cnt_nxt = w_reload;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end
   // state and counters; outputs are registered from the next state so they change cleanly on the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_set       <= '0;
         r_cnt_reset <= 1'b0;
         r_gate      <= 1'b0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_nxt;
         r_set       <= w_set_nxt;
         r_cnt_reset <= (w_next == S_CLEAR);
         r_gate      <= (w_next == S_GATE);
         r_valid     <= (w_next == S_HOLD);
         r_busy      <= (w_next != S_IDLE);
      end
   end
   // result holds the last capture until the final settle cycle of the next window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_result <= '0;
      else if (w_capture) r_result <= bus.count_in;
   end
   assign bus.cnt_reset    = r_cnt_reset;
   assign bus.gate         = r_gate;
   assign bus.result       = r_result;
   assign bus.result_valid = r_valid;
   assign bus.busy         = r_busy;
endmodule

// File: tb/tb_fmeas_ctrl.sv
// tb_fmeas_ctrl: timeline model of measurement windows checked every cycle, plus directed latency/count pins
module tb_fmeas_ctrl;
   localparam int LENGTH = 20;
   localparam int GATE_W = 16;
   localparam int SETTLE = 4;
`ifdef FMEAS_CONT_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int n_checks = 0;
   int n_errors = 0;
   fmeas_ctrl_if #(.LENGTH(LENGTH), .GATE_W(GATE_W)) bus ();
   fmeas_ctrl #(.LENGTH(LENGTH), .GATE_W(GATE_W), .SETTLE(SETTLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // external measurement counter: clears on cnt_reset, +1 per gated cycle
   logic [LENGTH-1:0] ext_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ext_cnt <= '0;
      else if (bus.cnt_reset) ext_cnt <= '0;
      else if (bus.gate) ext_cnt <= ext_cnt + 1'b1;
   end
   assign bus.count_in = ext_cnt;
   // model: a window is a timeline relative to its start edge t_acc
   int cyc = 0;
   int t_acc = 0;
   int m_n = 0;
   bit m_idle = 1'b1;
   logic [LENGTH-1:0] m_res = '0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle = 1'b1;
         m_res  = '0;
      end else begin
         cyc++;
         if (m_idle) begin
            if (bus.start) begin
               m_idle = 1'b0;
               t_acc  = cyc;
               m_n    = int'(bus.gate_cycles);
            end
         end else if (cyc - t_acc == m_n + SETTLE + 1) begin
            m_res = bus.count_in;
         end else if (cyc - t_acc >= m_n + SETTLE + 2 && bus.result_ready) begin
            if (CONT && bus.cont) t_acc = cyc;
            else m_idle = 1'b1;
         end
      end
   end
   // per-cycle comparison against the model
   always @(negedge clk) begin
      int rel;
      if (rst_n) begin
         rel = cyc - t_acc;
         chk("busy", bus.busy, !m_idle);
         chk("cnt_reset", bus.cnt_reset, !m_idle && rel == 0);
         chk("gate", bus.gate, !m_idle && rel >= 1 && rel <= m_n);
         chk("result_valid", bus.result_valid, !m_idle && rel >= m_n + SETTLE + 1);
         chk("result", bus.result, m_res);
      end
   end
   int gate_seen = 0;
   int crst_seen = 0;
   always @(negedge clk) begin
      if (bus.gate) gate_seen++;
      if (bus.cnt_reset) crst_seen++;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_valid(input bit do_start, input int n, input bit noise, output int lat);
      if (do_start) begin
         bus.gate_cycles = GATE_W'(n);
         bus.start = 1'b1;
      end
      lat = 0;
      forever begin
         tick();
         lat++;
         if (bus.result_valid || lat >= 400) break;
         bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.result_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) bus.gate_cycles = GATE_W'($urandom);
      end
      bus.start = 1'b0;
      bus.result_ready = 1'b0;
      if (!bus.result_valid) chk("valid_timeout", 0, 1);
   endtask
   task automatic handshake();
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
   endtask
   initial begin
      int lat;
      logic [LENGTH-1:0] r0;
      bus.start = 1'b0;
      bus.gate_cycles = '0;
      bus.cont = 1'b0;
      bus.result_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_busy", bus.busy, 0);
      chk("reset_gate", bus.gate, 0);
      chk("reset_cnt_reset", bus.cnt_reset, 0);
      chk("reset_valid", bus.result_valid, 0);
      chk("reset_result", bus.result, 0);
      tick();
      tick();
      rst_n = 1'b1;
      gate_seen = 0;
      crst_seen = 0;
      wait_valid(1'b1, 10, 1'b0, lat);
      chk("n10_latency", lat, 16);
      chk("n10_result", bus.result, 10);
      chk("n10_gate_cycles", gate_seen, 10);
      chk("n10_cnt_reset_cycles", crst_seen, 1);
      handshake();
      chk("n10_idle_after_ready", bus.busy, 0);
      gate_seen = 0;
      wait_valid(1'b1, 0, 1'b0, lat);
      chk("n0_latency", lat, 6);
      chk("n0_result", bus.result, 0);
      chk("n0_gate_cycles", gate_seen, 0);
      handshake();
      wait_valid(1'b1, 3, 1'b0, lat);
      chk("n3_result", bus.result, 3);
      r0 = bus.result;
      for (int i = 0; i < 20; i++) begin
         bus.start = 1'(i % 3 == 0);
         bus.gate_cycles = GATE_W'($urandom);
         tick();
         chk("hold_valid", bus.result_valid, 1);
         chk("hold_result", bus.result, r0);
      end
      handshake();
      chk("hold_exit_busy", bus.busy, 0);
      chk("hold_exit_valid", bus.result_valid, 0);
      bus.gate_cycles = GATE_W'(10);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      chk("midgate_gate_high", bus.gate, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midgate_rst_gate", bus.gate, 0);
      chk("midgate_rst_busy", bus.busy, 0);
      chk("midgate_rst_cnt_reset", bus.cnt_reset, 0);
      chk("midgate_rst_valid", bus.result_valid, 0);
      chk("midgate_rst_result", bus.result, 0);
      tick();
      tick();
      rst_n = 1'b1;
      gate_seen = 0;
      wait_valid(1'b1, 10, 1'b0, lat);
      chk("rerun_latency", lat, 16);
      chk("rerun_gate_cycles", gate_seen, 10);
      chk("rerun_result", bus.result, 10);
      handshake();
      for (int i = 0; i < 40; i++) begin
         int n;
         n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
         bus.cont = 1'($urandom_range(0, 1));
         wait_valid(!bus.busy, n, 1'b1, lat);
         repeat ($urandom_range(0, 5)) tick();
         handshake();
      end
      bus.cont = 1'b0;
      if (bus.busy) begin
         wait_valid(1'b0, 0, 1'b0, lat);
         handshake();
      end
      repeat (2) tick();
      bus.cont = 1'b1;
      bus.result_ready = 1'b1;
      bus.gate_cycles = GATE_W'(8);
      crst_seen = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (59) tick();
      chk("cont_cnt_reset_pulses", crst_seen, CONT ? 5 : 1);
      bus.cont = 1'b0;
      for (int i = 0; i < 40 && bus.busy; i++) tick();
      chk("cont_exit_busy", bus.busy, 0);
      bus.result_ready = 1'b0;
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
